seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_pkg.sv | 31 +++
 rtl/seg7_decode.sv | 27 ++
 rtl/seg7_scan_driver.sv | 160 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the two-digit seven-segment scan driver:
// scan states, active-high segment patterns and digit-enable codes.
package seg7_pkg;

  typedef enum logic [1:0] {
    S_ONES  = 2'd0,
    S_GAP_A = 2'd1,
    S_TENS  = 2'd2,
    S_GAP_B = 2'd3
  } state_e;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, 1 = segment lit
  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  // Active-low digit enables: an[0] drives the ones digit, an[1] the tens digit
  localparam logic [1:0] DIG_ONES = 2'b10;
  localparam logic [1:0] DIG_TENS = 2'b01;
  localparam logic [1:0] DIG_NONE = 2'b11;

endpackage

// File: rtl/seg7_decode.sv
// BCD code to active-high seven-segment pattern. Non-BCD codes show a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  // Pure lookup; anything outside 0-9 falls through to the dash
  always_comb begin
    seg_o = SEG_DASH;
    case (code_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Two-digit multiplexed seven-segment driver.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   S_ONES  | ones digit lit for CLK_DIV cycles
//   S_GAP_A | all digits off for GAP_CYCLES cycles
//   S_TENS  | tens digit lit (or blanked if leading zero)
//   S_GAP_B | all digits off; last cycle ends the frame
//
// Outputs are registered from the next-state view so seg/an change on
// the very edge that moves the FSM. The active register is refreshed
// from the capture register on the edge that opens each lit slot, so a
// load on that same edge only shows from the following lit slot.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 50000,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned LZ_BLANK       = 1,
  parameter int unsigned SEG_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] tens_bcd,
  input  logic [3:0] ones_bcd,
  input  logic       load,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_done
);

  localparam int unsigned SLOT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int unsigned CNT_W    = $clog2(SLOT_MAX + 1);
  localparam bit          GAP_EN   = (GAP_CYCLES != 0);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(CLK_DIV - 1);
  // With no gap, S_GAP_B is only visited once after reset and lasts one cycle
  localparam logic [CNT_W-1:0] GAP_LAST = GAP_EN ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [6:0] SEG_OFF_OUT = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             slot_end;
  logic [3:0]       cap_tens_q, cap_ones_q;
  logic [3:0]       act_tens_q, act_tens_d;
  logic [3:0]       act_ones_q, act_ones_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       an_q, an_d;
  logic             frame_q, frame_d;
  logic [3:0]       code_sel;
  logic [6:0]       pat;
  logic [6:0]       pat_on;

  seg7_decode u_decode (
    .code_i (code_sel),
    .seg_o  (pat)
  );

  // FSM state and slot counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_GAP_B;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: each slot ends when the counter hits its last index
  always_comb begin
    state_d  = state_q;
    slot_end = 1'b0;
    case (state_q)
      S_ONES: if (cnt_q == ON_LAST) begin
        slot_end = 1'b1;
        state_d  = GAP_EN ? S_GAP_A : S_TENS;
      end
      S_GAP_A: if (cnt_q == GAP_LAST) begin
        slot_end = 1'b1;
        state_d  = S_TENS;
      end
      S_TENS: if (cnt_q == ON_LAST) begin
        slot_end = 1'b1;
        state_d  = GAP_EN ? S_GAP_B : S_ONES;
      end
      S_GAP_B: if (cnt_q == GAP_LAST) begin
        slot_end = 1'b1;
        state_d  = S_ONES;
      end
      default: begin
        slot_end = 1'b1;
        state_d  = S_GAP_B;
      end
    endcase
    cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
  end

  // Active digits and registered display outputs for the upcoming cycle
  always_comb begin
    act_tens_d = act_tens_q;
    act_ones_d = act_ones_q;
    if (slot_end && (state_d == S_ONES || state_d == S_TENS)) begin
      act_tens_d = cap_tens_q;
      act_ones_d = cap_ones_q;
    end
    code_sel = (state_d == S_TENS) ? act_tens_d : act_ones_d;
    an_d     = DIG_NONE;
    pat_on   = SEG_OFF;
    case (state_d)
      S_ONES: begin
        an_d   = DIG_ONES;
        pat_on = pat;
      end
      S_TENS: if (!((LZ_BLANK != 0) && (act_tens_d == 4'd0))) begin
        an_d   = DIG_TENS;
        pat_on = pat;
      end
      default: begin
        an_d   = DIG_NONE;
        pat_on = SEG_OFF;
      end
    endcase
    seg_d   = (SEG_ACTIVE_LOW != 0) ? ~pat_on : pat_on;
    frame_d = GAP_EN ? ((state_d == S_GAP_B) && (cnt_d == GAP_LAST))
                     : ((state_d == S_TENS)  && (cnt_d == ON_LAST));
  end

  // Capture register follows load; reset clears it and masks load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_tens_q <= 4'd0;
      cap_ones_q <= 4'd0;
    end else if (load) begin
      cap_tens_q <= tens_bcd;
      cap_ones_q <= ones_bcd;
    end
  end

  // Active register and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_tens_q <= 4'd0;
      act_ones_q <= 4'd0;
      seg_q      <= SEG_OFF_OUT;
      an_q       <= DIG_NONE;
      frame_q    <= 1'b0;
    end else begin
      act_tens_q <= act_tens_d;
      act_ones_q <= act_ones_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      frame_q    <= frame_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: three instances (gap/blank/active-low,
// gap/no-blank/active-high, no-gap) checked against a schedule model
// that derives every cycle's display from frame arithmetic.
module tb_seg7_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] tens_bcd, ones_bcd;
  logic       load;
  logic [6:0] seg0, seg1, seg2;
  logic [1:0] an0, an1, an2;
  logic       fd0, fd1, fd2;

  int tests_run    = 0;
  int tests_failed = 0;
  int c = 0;
  logic [7:0] cap_hist [0:4095];
  logic [6:0] seg_tab [16];

  always #5 clk = ~clk;

  seg7_scan_driver #(.CLK_DIV(4), .GAP_CYCLES(2), .LZ_BLANK(1), .SEG_ACTIVE_LOW(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .tens_bcd(tens_bcd), .ones_bcd(ones_bcd), .load(load),
    .seg(seg0), .an(an0), .frame_done(fd0));
  seg7_scan_driver #(.CLK_DIV(4), .GAP_CYCLES(2), .LZ_BLANK(0), .SEG_ACTIVE_LOW(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tens_bcd(tens_bcd), .ones_bcd(ones_bcd), .load(load),
    .seg(seg1), .an(an1), .frame_done(fd1));
  seg7_scan_driver #(.CLK_DIV(4), .GAP_CYCLES(0), .LZ_BLANK(1), .SEG_ACTIVE_LOW(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .tens_bcd(tens_bcd), .ones_bcd(ones_bcd), .load(load),
    .seg(seg2), .an(an2), .frame_done(fd2));

  function automatic logic [9:0] obs(input int k);
    case (k)
      0:       return {an0, seg0, fd0};
      1:       return {an1, seg1, fd1};
      default: return {an2, seg2, fd2};
    endcase
  endfunction

  // Expected {an, seg, frame_done} for instance k, c cycles after the last reset edge.
  // Timeline: initial gap of max(G,1) cycles, then a period of ones D, gap G, tens D, gap G.
  function automatic logic [9:0] model_out(input int k, input int cc);
    int d, g, lz, al, init, per, p, base, kind, start;
    bit last, fd;
    logic [7:0] cv;
    logic [6:0] pt;
    logic [1:0] a;
    d  = 4;
    g  = (k == 2) ? 0 : 2;
    lz = (k == 1) ? 0 : 1;
    al = (k == 1) ? 0 : 1;
    init = (g > 0) ? g : 1;
    per  = 2 * d + 2 * g;
    if (cc < init) begin
      kind = 3; start = 0; last = (cc == init - 1);
    end else begin
      p = (cc - init) % per;
      base = cc - p;
      if (p < d) begin
        kind = 0; start = base; last = (p == d - 1);
      end else if (p < d + g) begin
        kind = 1; start = base + d; last = (p == d + g - 1);
      end else if (p < 2 * d + g) begin
        kind = 2; start = base + d + g; last = (p == 2 * d + g - 1);
      end else begin
        kind = 3; start = base + 2 * d + g; last = (p == per - 1);
      end
    end
    a  = 2'b11;
    pt = 7'h00;
    if (kind == 0) begin
      cv = cap_hist[start - 1];
      a  = 2'b10;
      pt = seg_tab[cv[3:0]];
    end else if (kind == 2) begin
      cv = cap_hist[start - 1];
      if (!(lz == 1 && cv[7:4] == 4'd0)) begin
        a  = 2'b01;
        pt = seg_tab[cv[7:4]];
      end
    end
    if (al == 1) pt = ~pt;
    fd = (cc >= 1) && last && ((g > 0 && kind == 3) || (g == 0 && kind == 2));
    return {a, pt, fd};
  endfunction

  // Advance one clock and mirror the capture register into the model history
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      c = 0;
      cap_hist[0] = 8'h00;
    end else begin
      if (c < 4095) c++;
      cap_hist[c] = load ? {tens_bcd, ones_bcd} : cap_hist[c - 1];
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    load  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b1; tens_bcd = 4'd9; ones_bcd = 4'd9;
    tick();
    tick();
    tests_run++;
    if ({an0, seg0, fd0} !== {2'b11, 7'b1111111, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_dut0 got=%b want=%b", {an0, seg0, fd0}, {2'b11, 7'b1111111, 1'b0});
    end
    tests_run++;
    if ({an1, seg1, fd1} !== {2'b11, 7'b0000000, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_dut1 got=%b want=%b", {an1, seg1, fd1}, {2'b11, 7'b0000000, 1'b0});
    end
    load = 1'b0; rst_n = 1'b1;
    tick();
    tick();
    tests_run++;
    if ({an0, seg0} !== {2'b10, 7'b1000000}) begin
      tests_failed++;
      $display("FAIL reset_first_ones got=%b want=%b", {an0, seg0}, {2'b10, 7'b1000000});
    end
  endtask

  task automatic test_scan_timing();
    int n_fd, n_ones, n_tens;
    n_fd = 0; n_ones = 0; n_tens = 0;
    do_reset();
    load = 1'b1; tens_bcd = 4'd4; ones_bcd = 4'd2;
    tick();
    load = 1'b0;
    if (fd0) n_fd++;
    for (int i = 0; i < 35; i++) begin
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (obs(k) !== model_out(k, c)) begin
          tests_failed++;
          $display("FAIL scan_model dut%0d c=%0d got=%b want=%b", k, c, obs(k), model_out(k, c));
        end
      end
      if (an0 == 2'b10) begin
        n_ones++;
        tests_run++;
        if (seg0 !== 7'b0100100) begin
          tests_failed++;
          $display("FAIL scan_ones_seg c=%0d got=%b want=%b", c, seg0, 7'b0100100);
        end
      end
      if (an0 == 2'b01) begin
        n_tens++;
        tests_run++;
        if (seg0 !== 7'b0011001) begin
          tests_failed++;
          $display("FAIL scan_tens_seg c=%0d got=%b want=%b", c, seg0, 7'b0011001);
        end
      end
      tick();
      if (fd0 && c <= 36) n_fd++;
    end
    tests_run++;
    if ({n_fd, n_ones, n_tens} !== {32'd3, 32'd12, 32'd12}) begin
      tests_failed++;
      $display("FAIL scan_counts got fd=%0d ones=%0d tens=%0d want fd=3 ones=12 tens=12",
               n_fd, n_ones, n_tens);
    end
  endtask

  task automatic test_lz_blank();
    int n_tens0;
    n_tens0 = 0;
    do_reset();
    load = 1'b1; tens_bcd = 4'd0; ones_bcd = 4'd7;
    tick();
    load = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        tests_run++;
        if (obs(k) !== model_out(k, c)) begin
          tests_failed++;
          $display("FAIL lz_model dut%0d c=%0d got=%b want=%b", k, c, obs(k), model_out(k, c));
        end
      end
      if (an0 == 2'b01) n_tens0++;
      if (an0 == 2'b10) begin
        tests_run++;
        if (seg0 !== 7'b1111000) begin
          tests_failed++;
          $display("FAIL lz_ones_seg c=%0d got=%b want=%b", c, seg0, 7'b1111000);
        end
      end
      if (an1 == 2'b01) begin
        tests_run++;
        if (seg1 !== ~7'b1000000) begin
          tests_failed++;
          $display("FAIL lz_off_tens_seg c=%0d got=%b want=%b", c, seg1, ~7'b1000000);
        end
      end
    end
    tests_run++;
    if (n_tens0 != 0) begin
      tests_failed++;
      $display("FAIL lz_tens_enabled got=%0d cycles want=0", n_tens0);
    end
  endtask

  task automatic test_invalid_bcd();
    do_reset();
    load = 1'b1; tens_bcd = 4'hC; ones_bcd = 4'hF;
    tick();
    load = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      tests_run++;
      if (obs(0) !== model_out(0, c)) begin
        tests_failed++;
        $display("FAIL invalid_model c=%0d got=%b want=%b", c, obs(0), model_out(0, c));
      end
      if (an0 != 2'b11) begin
        tests_run++;
        if (seg0 !== 7'b0111111) begin
          tests_failed++;
          $display("FAIL invalid_dash c=%0d an=%b got=%b want=%b", c, an0, seg0, 7'b0111111);
        end
      end
    end
  endtask

  task automatic test_load_at_slot_start();
    do_reset();
    load = 1'b1; tens_bcd = 4'd1; ones_bcd = 4'd1;
    tick();
    load = 1'b0;
    tick();
    load = 1'b1; tens_bcd = 4'd5; ones_bcd = 4'd3;
    tick();
    load = 1'b0;
    while (c < 16) begin
      tests_run++;
      if (obs(0) !== model_out(0, c)) begin
        tests_failed++;
        $display("FAIL slotload_model c=%0d got=%b want=%b", c, obs(0), model_out(0, c));
      end
      if (c >= 3 && c <= 5) begin
        tests_run++;
        if (seg0 !== 7'b1111001) begin
          tests_failed++;
          $display("FAIL slotload_hold c=%0d got=%b want=%b", c, seg0, 7'b1111001);
        end
      end
      if (c >= 8 && c <= 11) begin
        tests_run++;
        if (seg0 !== 7'b0010010) begin
          tests_failed++;
          $display("FAIL slotload_new_tens c=%0d got=%b want=%b", c, seg0, 7'b0010010);
        end
      end
      if (c == 14) begin
        tests_run++;
        if (seg0 !== 7'b0110000) begin
          tests_failed++;
          $display("FAIL slotload_new_ones c=%0d got=%b want=%b", c, seg0, 7'b0110000);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_slot();
    do_reset();
    load = 1'b1; tens_bcd = 4'd6; ones_bcd = 4'd8;
    tick();
    load = 1'b0;
    while (c < 9) tick();
    tests_run++;
    if (an0 !== 2'b01) begin
      tests_failed++;
      $display("FAIL midreset_pre an got=%b want=%b", an0, 2'b01);
    end
    rst_n = 1'b0;
    tick();
    tests_run++;
    if ({an0, seg0, fd0} !== {2'b11, 7'b1111111, 1'b0}) begin
      tests_failed++;
      $display("FAIL midreset_off got=%b want=%b", {an0, seg0, fd0}, {2'b11, 7'b1111111, 1'b0});
    end
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (an0 !== 2'b11) begin
      tests_failed++;
      $display("FAIL midreset_gap an got=%b want=%b", an0, 2'b11);
    end
    tick();
    tests_run++;
    if ({an0, seg0} !== {2'b10, 7'b1000000}) begin
      tests_failed++;
      $display("FAIL midreset_zero got=%b want=%b", {an0, seg0}, {2'b10, 7'b1000000});
    end
  endtask

  task automatic test_gap_bypass();
    int n_fd, n_off, last_fd;
    n_fd = 0; n_off = 0; last_fd = -1;
    do_reset();
    load = 1'b1; tens_bcd = 4'd4; ones_bcd = 4'd2;
    tick();
    load = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tests_run++;
      if (obs(2) !== model_out(2, c)) begin
        tests_failed++;
        $display("FAIL bypass_model c=%0d got=%b want=%b", c, obs(2), model_out(2, c));
      end
      if (an2 == 2'b11) n_off++;
      if (fd2) begin
        n_fd++;
        if (last_fd >= 0) begin
          tests_run++;
          if (c - last_fd != 8) begin
            tests_failed++;
            $display("FAIL bypass_frame_period got=%0d want=8", c - last_fd);
          end
        end
        last_fd = c;
      end
      tick();
    end
    tests_run++;
    if ({n_fd, n_off} !== {32'd5, 32'd0}) begin
      tests_failed++;
      $display("FAIL bypass_counts got fd=%0d off=%0d want fd=5 off=0", n_fd, n_off);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 900; i++) begin
      load     = ($urandom_range(0, 5) == 0);
      tens_bcd = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      ones_bcd = 4'($urandom_range(0, 15));
      rst_n    = ($urandom_range(0, 149) != 0);
      tick();
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (obs(k) !== model_out(k, c)) begin
          tests_failed++;
          $display("FAIL random dut%0d c=%0d got=%b want=%b", k, c, obs(k), model_out(k, c));
        end
      end
    end
    rst_n = 1'b1;
    load  = 1'b0;
  endtask

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    rst_n = 1'b0; load = 1'b0; tens_bcd = 4'd0; ones_bcd = 4'd0;
    test_reset();
    test_scan_timing();
    test_lz_blank();
    test_invalid_bcd();
    test_load_at_slot_start();
    test_reset_mid_slot();
    test_gap_bypass();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
